// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM counter/compare stage.
package pwm_pkg;

    localparam int PWM_CNT_W = 16;
    localparam int PWM_DT_W  = 8;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    typedef enum logic {
        PWM_POL_HIGH = 1'b0,
        PWM_POL_LOW  = 1'b1
    } pwm_pol_e;

    // Map an internal active level onto the pin level for the given polarity.
    function automatic logic pwm_drive(input logic active, input pwm_pol_e pol);
        return active ^ (pol == PWM_POL_LOW);
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion between the main and complementary PWM legs.
// Only built when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ACT,
    input  logic [DT_W-1:0] DEADTIME,
    output logic            OUT_P,
    output logic            OUT_N
);

    logic            prev_q, prev_d;
    logic [DT_W-1:0] run_q, run_d;

    // run_d counts how many earlier cycles ACT has already held its current value.
    always_comb begin
        prev_d = ACT;
        run_d  = '0;
        if (ACT == prev_q) begin
            run_d = (run_q == '1) ? run_q : run_q + 1'b1;
        end
    end

    // Level history; restarts after reset as if ACT had been low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_q <= 1'b0;
            run_q  <= '0;
        end else begin
            prev_q <= prev_d;
            run_q  <= run_d;
        end
    end

    // Each leg waits out the dead time before going active; it drops on its own edge.
    assign OUT_P = ACT  & (run_d >= DEADTIME);
    assign OUT_N = ~ACT & (run_d >= DEADTIME);

endmodule
`endif

// File: rtl/pwm_counter_compare.sv
// PWM counter/compare stage: tick counter, double-buffered period/duty,
// comparator and registered main/complementary outputs.
// Optional dead-time insertion is enabled by defining PWM_DEADTIME_EN.
module pwm_counter_compare
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W,
    parameter int DT_W  = PWM_DT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PWM_CLKE,
    input  logic             EN,
    input  logic [CNT_W-1:0] PERIOD,
    input  logic [CNT_W-1:0] DUTY,
    input  logic             POLARITY,
    input  logic [DT_W-1:0]  DEADTIME,
    output logic             PWM_OUT,
    output logic             PWM_OUT_N,
    output logic             PERIOD_END,
    output logic [CNT_W-1:0] CNT
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             period_end_q, period_end_d;
    logic             out_p_q, out_p_d;
    logic             out_n_q, out_n_d;
    logic             act;
    logic             wrap;
    logic             out_p_raw;
    logic             out_n_raw;

    assign act  = (cnt_q < duty_sh_q);
    assign wrap = PWM_CLKE & (cnt_q == per_sh_q);

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DT_W (DT_W)
    ) u_deadtime (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ACT      (act),
        .DEADTIME (DEADTIME),
        .OUT_P    (out_p_raw),
        .OUT_N    (out_n_raw)
    );
`else
    logic unused_deadtime;
    assign unused_deadtime = ^DEADTIME;
    assign out_p_raw = act;
    assign out_n_raw = ~act;
`endif

    // Counter advance, shadow reloads at wrap (or continuously while disabled), output levels.
    always_comb begin
        cnt_d        = cnt_q;
        per_sh_d     = per_sh_q;
        duty_sh_d    = duty_sh_q;
        period_end_d = 1'b0;
        if (!EN) begin
            cnt_d     = '0;
            per_sh_d  = PERIOD;
            duty_sh_d = DUTY;
        end else begin
            if (PWM_CLKE) begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
            end
            if (wrap) begin
                per_sh_d  = PERIOD;
                duty_sh_d = DUTY;
            end
            period_end_d = wrap;
        end
        out_p_d = EN & out_p_raw;
        out_n_d = EN & out_n_raw;
    end

    // State registers; outputs are held as active levels so reset means "inactive".
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q        <= '0;
            per_sh_q     <= '0;
            duty_sh_q    <= '0;
            period_end_q <= 1'b0;
            out_p_q      <= 1'b0;
            out_n_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            per_sh_q     <= per_sh_d;
            duty_sh_q    <= duty_sh_d;
            period_end_q <= period_end_d;
            out_p_q      <= out_p_d;
            out_n_q      <= out_n_d;
        end
    end

    // Polarity is applied after the registers so the pins show the inactive
    // level during reset without needing an asynchronously loaded flop.
    assign PWM_OUT    = pwm_drive(out_p_q, pwm_pol_e'(POLARITY));
    assign PWM_OUT_N  = pwm_drive(out_n_q, pwm_pol_e'(POLARITY));
    assign PERIOD_END = period_end_q;
    assign CNT        = cnt_q;

endmodule
